// File: rtl/cnn_layer_accel_pkg.sv
// rtl/cnn_layer_accel_pkg.sv - shared types and constants for the weight-table sequencer
package cnn_layer_accel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    EXEC   = 2'd2,
    DRAIN  = 2'd3
  } wht_seq_state_t;

  localparam int         WHT_TAP_PAIRS = 5;
  localparam logic [3:0] WHT_PAD_SLOT  = 4'hF;
  localparam int         KERNEL_WORDS  = 16;

  // Tap pair p reads taps 2p and 2p+1; the last pair pairs tap 8 with the zero slot.
  function automatic logic [7:0] wht_tap_pair(input logic [2:0] pair);
    logic [3:0] even_tap;
    logic [7:0] result;
    even_tap = {pair, 1'b0};
    if (pair == 3'(WHT_TAP_PAIRS - 1)) result = {even_tap, WHT_PAD_SLOT};
    else                               result = {even_tap, even_tap | 4'd1};
    return result;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_tap_pair_gen.sv
// rtl/cnn_layer_accel_tap_pair_gen.sv - tap pair counter and dual-port address ROM
module cnn_layer_accel_tap_pair_gen
  import cnn_layer_accel_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       start,
  input  logic       advance,
  output logic       last_pair,
  output logic [3:0] addr0,
  output logic [3:0] addr1
);

  logic [2:0] pair_cnt;
  logic [2:0] pair_nxt;
  logic [7:0] rom_nxt;

  assign last_pair = (pair_cnt == 3'(WHT_TAP_PAIRS - 1));

  // Next pair index: start always reloads pair 0, otherwise step and wrap after the pad pair.
  always_comb begin
    pair_nxt = last_pair ? 3'd0 : pair_cnt + 3'd1;
    if (start) pair_nxt = 3'd0;
    rom_nxt = wht_tap_pair(pair_nxt);
  end

  // Addresses are registered together with the pair index so they hold whenever advance is low.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pair_cnt <= 3'd0;
      addr0    <= 4'd0;
      addr1    <= 4'd0;
    end else if (start || advance) begin
      pair_cnt       <= pair_nxt;
      {addr0, addr1} <= rom_nxt;
    end
  end

endmodule

// File: rtl/cnn_layer_accel_wht_seq_ctrl.sv
// rtl/cnn_layer_accel_wht_seq_ctrl.sv - weight-table sequencer (optional stall input under WHT_SEQ_STALL_EN)
module cnn_layer_accel_wht_seq_ctrl
  import cnn_layer_accel_pkg::*;
#(
  parameter int C_NUM_KERNELS_W = 6,
  parameter int C_NUM_WINDOWS_W = 16,
  parameter int C_DRAIN_CYCLES  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_start,
  input  logic [C_NUM_KERNELS_W-1:0] num_kernels,
  input  logic [C_NUM_WINDOWS_W-1:0] num_windows,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  output logic                       config_mode,
  output logic                       wht_config_wren,
  output logic                       ce_execute,
  output logic [3:0]                 wht_seq_addr0,
  output logic [3:0]                 wht_seq_addr1,
  output logic                       next_kernel,
  input  logic                       slv_rd_req,
  output logic                       slv_rd_gnt,
  output logic                       busy,
  output logic                       job_done
`ifdef WHT_SEQ_STALL_EN
  ,
  input  logic                       ce_stall
`endif
);

  localparam int DW = $clog2(C_DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]              DRAIN_LAST = DW'(C_DRAIN_CYCLES - 1);
  localparam logic [DW-1:0]              D_ONE      = DW'(1);
  localparam logic [C_NUM_KERNELS_W-1:0] K_ONE      = C_NUM_KERNELS_W'(1);
  localparam logic [C_NUM_WINDOWS_W-1:0] W_ONE      = C_NUM_WINDOWS_W'(1);

  wht_seq_state_t             state;
  logic                       start_pend;
  logic [C_NUM_KERNELS_W-1:0] kern_q;
  logic [C_NUM_WINDOWS_W-1:0] win_q;
  logic [3:0]                 word_cnt;
  logic [C_NUM_KERNELS_W-1:0] cfg_kidx;
  logic [C_NUM_WINDOWS_W-1:0] win_cnt;
  logic [C_NUM_KERNELS_W-1:0] kidx;
  logic [DW-1:0]              drain_cnt;
  logic                       nk_pend;

  logic stall_now;
  logic cfg_last;
  logic exec_step;
  logic last_pair;
  logic win_end;
  logic kern_end;
  logic job_end;

`ifdef WHT_SEQ_STALL_EN
  assign stall_now = (state == EXEC) && ce_stall;
`else
  assign stall_now = 1'b0;
`endif

  assign cfg_ready       = (state == CONFIG);
  assign config_mode     = (state == CONFIG);
  assign wht_config_wren = cfg_valid && cfg_ready;
  assign ce_execute      = (state == EXEC);
  assign busy            = (state != IDLE);
  assign slv_rd_gnt      = slv_rd_req && (state == IDLE);
  assign job_done        = (state == DRAIN) && (drain_cnt == DRAIN_LAST);
  // A pending kernel boundary waits out any stall cycle before it is shown.
  assign next_kernel     = nk_pend && !stall_now;

  assign cfg_last  = wht_config_wren && (word_cnt == 4'(KERNEL_WORDS - 1)) && (cfg_kidx == kern_q);
  assign exec_step = (state == EXEC) && !stall_now;
  assign win_end   = exec_step && last_pair;
  assign kern_end  = win_end && (win_cnt == win_q);
  assign job_end   = kern_end && (kidx == kern_q);

  cnn_layer_accel_tap_pair_gen u_tap_pair_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == IDLE),
    .start     (cfg_last),
    .advance   (exec_step && !job_end),
    .last_pair (last_pair),
    .addr0     (wht_seq_addr0),
    .addr1     (wht_seq_addr1)
  );

  // Job FSM: weight load, tap sequencing, pipeline drain; a start that loses to a read-back grant is deferred one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      start_pend <= 1'b0;
      kern_q     <= '0;
      win_q      <= '0;
      word_cnt   <= 4'd0;
      cfg_kidx   <= '0;
      win_cnt    <= '0;
      kidx       <= '0;
      drain_cnt  <= '0;
      nk_pend    <= 1'b0;
    end else begin
      if (next_kernel) nk_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (job_start && !start_pend) begin
            kern_q <= num_kernels;
            win_q  <= num_windows;
          end
          if (start_pend || (job_start && !slv_rd_req)) begin
            state      <= CONFIG;
            start_pend <= 1'b0;
            word_cnt   <= 4'd0;
            cfg_kidx   <= '0;
          end else if (job_start) begin
            start_pend <= 1'b1;
          end
        end
        CONFIG: begin
          if (wht_config_wren) begin
            word_cnt <= word_cnt + 4'd1;
            if (word_cnt == 4'(KERNEL_WORDS - 1)) cfg_kidx <= cfg_kidx + K_ONE;
            if (cfg_last) begin
              state   <= EXEC;
              win_cnt <= '0;
              kidx    <= '0;
            end
          end
        end
        EXEC: begin
          if (win_end) begin
            win_cnt <= win_cnt + W_ONE;
            if (kern_end) begin
              win_cnt <= '0;
              kidx    <= kidx + K_ONE;
              nk_pend <= 1'b1;
            end
            if (job_end) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= IDLE;
          else                         drain_cnt <= drain_cnt + D_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
